// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and a counter-width helper.
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
// SERIAL_ADDER_OVERFLOW_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVERFLOW_EN
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder reused by the serial adder every cycle.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned    CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept_c;
  logic             last_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q;
`endif

  serial_fa_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // A new add may only begin when no bits are in flight.
  assign accept_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_c   = (state_q == RUN) && (cnt_q == LAST_BIT);

  assign a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
  assign b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
  assign sum_d  = {fa_s, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept_c) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // Sum fills from the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
          sum_q   <= sum_d;
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_ONE;
          if (last_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // carry_q is the carry into the MSB on the last bit.
            ovf_q   <= carry_q ^ fa_co;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level reference model plus directed and random stimulus.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   cmp_en;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an add takes W edges after acceptance, then one done cycle.
  int             m_rem;
  bit             m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0]   m_sum;
  logic [W:0]     p_res;
  bit             p_ovf;
  int             sv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end else if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
        {m_cout, m_sum} = p_res;
        m_ovf = p_ovf;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
        p_res  = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
        sv     = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
        p_ovf  = (sv > 127) || (sv < -128);
        m_rem  = W;
        m_busy = 1;
      end
    end
  end

  // Every-cycle comparison against the model; sum/cout only meaningful when not busy.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      if (!m_busy) begin
        check("sum", 64'(bus.sum), 64'(m_sum));
        check("cout", 64'(bus.cout), 64'(m_cout));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf", 64'(bus.ovf), 64'(m_ovf));
`endif
      end
    end
  end

  task automatic drive(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    bus.start = s; bus.a = a; bus.b = b; bus.cin = c;
  endtask

  // Waits at negedges for done; n counts negedges elapsed.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 30);
    if (!bus.done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit c, output int n);
    drive(1'b1, a, b, c);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int n;
    int dcount;
    errors = 0; checks = 0; cmp_en = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_sum",  64'(bus.sum),  64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);

    // 0x5A + 0x3C: done appears W edges after the accepting edge.
    run_op(8'h5A, 8'h3C, 1'b0, n);
    check("latency", 64'(n), 64'(W));
    check("sum_5a3c", 64'(bus.sum), 64'h96);
    check("cout_5a3c", 64'(bus.cout), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'(0));

    run_op(8'hFF, 8'h01, 1'b0, n);
    check("sum_ff01", 64'(bus.sum), 64'h00);
    check("cout_ff01", 64'(bus.cout), 64'(1));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("ovf_ff01", 64'(bus.ovf), 64'(0));
`endif
    @(negedge clk);

    run_op(8'h7F, 8'h01, 1'b0, n);
    check("sum_7f01", 64'(bus.sum), 64'h80);
    check("cout_7f01", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("ovf_7f01", 64'(bus.ovf), 64'(1));
`endif
    @(negedge clk);

    // Start pulsed mid-run must be ignored.
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    wait_done(n);
    check("sum_ign", 64'(bus.sum), 64'hFF);
    check("cout_ign", 64'(bus.cout), 64'(1));
    repeat (3) @(negedge clk);
    check("ign_no_restart", 64'(bus.busy), 64'(0));

    // Back-to-back with start held high.
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h80, 8'h80, 1'b0);
    wait_done(n);
    check("b2b_sum0", 64'(bus.sum), 64'h03);
    check("b2b_cout0", 64'(bus.cout), 64'(0));
    wait_done(n);
    drive(1'b0, '0, '0, 1'b0);
    check("b2b_spacing", 64'(n), 64'(W + 1));
    check("b2b_sum1", 64'(bus.sum), 64'h00);
    check("b2b_cout1", 64'(bus.cout), 64'(1));
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run discards the add.
    drive(1'b1, 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 64'(bus.busy), 64'(0));
    check("mrst_done", 64'(bus.done), 64'(0));
    check("mrst_sum",  64'(bus.sum),  64'(0));
    check("mrst_cout", 64'(bus.cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("mrst_no_done", 64'(dcount), 64'(0));

    // Random traffic, including starts during runs and back-to-back accepts.
    repeat (600) begin
      drive(1'(($urandom % 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
      @(negedge clk);
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (W + 4) @(negedge clk);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
